// File: rtl/quant_calibrator.sv
// quant_calibrator: tracks FP32 window min/max (range always spans 0) and emits INT8 qscale/qzero.
// Latency: final sample accepted at edge T -> COMPUTE cycle T+1 -> out_valid high in cycle T+2.
// Backpressure: in_ready drops for COMPUTE/HOLD; results hold stable in HOLD until out_ready.
// Optional build macro QUANT_CALIB_SYMMETRIC_EN selects symmetric (absmax/127, qzero=0) calibration.

package nn_dtypes_pkg;

  typedef logic [31:0]        fp32_t;
  typedef logic signed [7:0]  int8_t;

  typedef struct packed {
    fp32_t qscale;
    int8_t qzero;
  } qparam_t;

  localparam fp32_t FP32_ONE = 32'h3F80_0000;

  // Exact widening of a finite FP32 value to a double.
  function automatic real fp32_to_real(input fp32_t f);
    logic [63:0] d;
    real         mag;
    if (f[30:23] == 8'd0) begin
      // Subnormal (or zero): mantissa scaled by 2^-149.
      mag = real'(f[22:0]) * 1.401298464324817e-45;
      return f[31] ? -mag : mag;
    end
    d = {f[31], {3'b000, f[30:23]} + 11'd896, f[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  // Double to FP32 with round-to-nearest-even, including subnormal results and overflow to Inf.
  function automatic fp32_t real_to_fp32(input real r);
    logic [63:0] d;
    logic [10:0] e;
    logic [63:0] full;
    logic [63:0] rem;
    logic [63:0] half;
    logic [30:0] kept;
    logic [7:0]  base;
    int          ex;
    int          sh;
    d = $realtobits(r);
    e = d[62:52];
    if (e == 11'd0) return {d[63], 31'd0};
    if (e == 11'h7FF) return {d[63], 8'hFF, (d[51:0] != 52'd0) ? 23'h40_0000 : 23'd0};
    ex = int'({21'd0, e}) - 1023;
    if (ex > 127) return {d[63], 8'hFF, 23'd0};
    full = {11'd0, 1'b1, d[51:0]};
    if (ex >= -126) begin
      sh   = 29;
      base = 8'(ex + 126);
    end else begin
      sh   = 29 + (-126 - ex);
      base = 8'd0;
    end
    if (sh > 60) return {d[63], 31'd0};
    kept = 31'(full >> sh);
    rem  = full & ((64'd1 << sh) - 64'd1);
    half = 64'd1 << (sh - 1);
    if ((rem > half) || ((rem == half) && kept[0])) kept = kept + 31'd1;
    // The hidden bit (and any rounding carry) ripples straight into the exponent field.
    return {d[63], {base, 23'd0} + kept};
  endfunction

endpackage

module quant_calibrator
  import nn_dtypes_pkg::*;
#(
  parameter int WINDOW = 16,
  parameter int CNT_W  = $clog2(WINDOW + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  fp32_t            in_fp32,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output fp32_t            out_qscale,
  output int8_t            out_qzero,
  output fp32_t            out_min,
  output fp32_t            out_max,
  output logic [CNT_W-1:0] out_count,
  output logic             busy
);

  typedef enum logic [1:0] {
    ST_ACCUM   = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_HOLD    = 2'd2
  } state_t;

  state_t           state;
  fp32_t            min_q;
  fp32_t            max_q;
  logic [CNT_W-1:0] cnt_q;

  logic             accept;
  logic             finite;
  logic [CNT_W-1:0] cnt_nxt;
  fp32_t            min_nxt;
  fp32_t            max_nxt;
  logic             close_win;

  qparam_t          par;
  fp32_t            res_min;
  fp32_t            res_max;

  // Asymmetric parameters: the range [min, max] always straddles zero.
  function automatic qparam_t calc_asym(input fp32_t mn, input fp32_t mx);
    qparam_t p;
    real     mn_r;
    real     rng;
    real     sc;
    real     q;
    mn_r     = fp32_to_real(mn);
    rng      = fp32_to_real(mx) - mn_r;
    p.qscale = FP32_ONE;
    p.qzero  = 8'h00;
    if (rng != 0.0) begin
      sc = rng / 255.0;
      q  = -128.0 - mn_r / sc;
      // Clamp before rounding so int'() never sees an out-of-range value.
      if (q >= 127.0)       p.qzero = 8'h7F;
      else if (q <= -128.0) p.qzero = 8'h80;
      else                  p.qzero = int8_t'(int'(q));
      p.qscale = real_to_fp32(sc);
    end
    return p;
  endfunction

  // Symmetric parameters from the largest finite magnitude seen.
  function automatic qparam_t calc_sym(input logic [30:0] absmax);
    qparam_t p;
    p.qzero  = 8'h00;
    p.qscale = FP32_ONE;
    if (absmax != 31'd0) p.qscale = real_to_fp32(fp32_to_real({1'b0, absmax}) / 127.0);
    return p;
  endfunction

  // Sample acceptance and running min/max; compares are sign-magnitude since min<=0<=max.
  always_comb begin
    accept  = in_valid && in_ready;
    finite  = (in_fp32[30:23] != 8'hFF);
    cnt_nxt = cnt_q + CNT_W'(accept);
    min_nxt = min_q;
    max_nxt = max_q;
    if (accept && finite) begin
      if (in_fp32[31] && (in_fp32[30:0] > min_q[30:0]))  min_nxt = in_fp32;
      if (!in_fp32[31] && (in_fp32[30:0] > max_q[30:0])) max_nxt = in_fp32;
    end
    close_win = (accept && (cnt_nxt == CNT_W'(WINDOW))) || (flush && (cnt_nxt != '0));
  end

  // Quantisation parameters from the closed window, registered during COMPUTE.
  always_comb begin
    par     = '0;
    res_min = min_q;
    res_max = max_q;
`ifdef QUANT_CALIB_SYMMETRIC_EN
    begin
      logic [30:0] absmax;
      absmax  = (min_q[30:0] > max_q[30:0]) ? min_q[30:0] : max_q[30:0];
      par     = calc_sym(absmax);
      res_min = (absmax == 31'd0) ? 32'd0 : {1'b1, absmax};
      res_max = {1'b0, absmax};
    end
`else
    par = calc_asym(min_q, max_q);
`endif
  end

  // Window FSM with registered handshake, status and result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_ACCUM;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      out_qscale <= '0;
      out_qzero  <= '0;
      out_min    <= '0;
      out_max    <= '0;
      out_count  <= '0;
      min_q      <= '0;
      max_q      <= '0;
      cnt_q      <= '0;
    end else begin
      case (state)
        ST_ACCUM: begin
          if (accept) begin
            cnt_q <= cnt_nxt;
            min_q <= min_nxt;
            max_q <= max_nxt;
          end
          if (close_win) begin
            state    <= ST_COMPUTE;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        ST_COMPUTE: begin
          out_qscale <= par.qscale;
          out_qzero  <= par.qzero;
          out_min    <= res_min;
          out_max    <= res_max;
          out_count  <= cnt_q;
          out_valid  <= 1'b1;
          state      <= ST_HOLD;
        end
        ST_HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            min_q     <= '0;
            max_q     <= '0;
            cnt_q     <= '0;
            state     <= ST_ACCUM;
          end
        end
        default: begin
          state     <= ST_ACCUM;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/quant_calibrator.md
Name: quant_calibrator

Overview:
- Streaming calibration stage that sits upstream of the format-conversion block.
- Consumes a window of FP32 activations over a valid/ready handshake and tracks the window's min/max.
- At window close, computes the INT8 quantisation parameters (qscale, qzero) and presents them on a valid/ready output. The conversion block's quantise and dequantise ops consume these parameters directly.
- Uses the nn_dtypes_pkg types and fp32/real conversion functions.

Parameters:
- WINDOW, 16, samples per calibration window (>=1)
- CNT_W, $clog2(WINDOW+1), width of sample counter

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- in_valid  input  1  sample valid
- in_ready  output  1  block can accept a sample
- in_fp32  input  32  FP32 sample (fp32_t)
- flush  input  1  close the current window early
- out_valid  output  1  parameters valid
- out_ready  input  1  consumer accepts parameters
- out_qscale  output  32  FP32 scale (fp32_t)
- out_qzero  output  8  signed zero point (int8_t)
- out_min  output  32  FP32 window minimum, zero-extended range
- out_max  output  32  FP32 window maximum, zero-extended range
- out_count  output  CNT_W  samples accepted in the window
- busy  output  1  high in COMPUTE or HOLD

Behaviour:
- One clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - state=ACCUM, in_ready=1, out_valid=0.
  - out_qscale=0, out_qzero=0, out_min=0, out_max=0, out_count=0, busy=0.
  - Internal min=+0.0, max=+0.0, count=0.
  - Reset mid-window or mid-HOLD discards everything; no output is produced.
- Range always includes 0: min and max start at 0.0 each window. This is standard asymmetric INT8 calibration.
- FSM states: ACCUM, COMPUTE, HOLD.
- ACCUM:
  - in_ready=1. A sample is accepted when in_valid & in_ready.
  - On accept: count++. If the sample is finite, min=min(min,x) and max=max(max,x).
  - NaN and ±Inf samples (exponent 0xFF) are counted but excluded from min/max.
  - Go to COMPUTE after the accept that makes count==WINDOW.
  - Also go to COMPUTE when flush=1 and count (including a same-cycle accept) >=1.
  - flush with count==0 and no accept is ignored; state stays ACCUM.
  - Sample and flush in the same cycle: the sample is included, then COMPUTE.
- COMPUTE (exactly 1 cycle):
  - in_ready=0.
  - Registers out_min, out_max, out_count.
  - range = max-min. If range==0: qscale=1.0 (0x3F800000), qzero=0.
  - Otherwise: qscale = range/255, and qzero = clamp(round(-128 - min/qscale), -128, 127).
  - round = round-half-away-from-zero (SV int'() of real).
  - Results are converted with real_to_fp32. Then go to HOLD.
- HOLD:
  - out_valid=1, in_ready=0. All outputs are held stable until out_ready.
  - On out_valid & out_ready: out_valid=0, internal min/max/count cleared, state goes to ACCUM. in_ready=1 from the next cycle.
  - flush in HOLD is ignored.
- Latency: final sample accepted in cycle T → COMPUTE in T+1 → out_valid=1 in T+2. Minimum 3 cycles per window turnaround beyond sample accepts.
- out_* registers keep their last values after handshake until the next COMPUTE.
- busy = (state != ACCUM).

Optional Feature:
- Macro: QUANT_CALIB_SYMMETRIC_EN.
- Defined:
  - absmax = max(|min|, |max|), over finite samples.
  - qscale = absmax/127; qzero=0 always.
  - absmax==0 gives qscale=1.0.
  - out_min=-absmax, out_max=+absmax.
- Undefined: asymmetric behaviour above.
- Handshake and FSM are unchanged either way.

Test Plan:
- WINDOW=4, samples {-1.0, 0.5, 2.0, 3.0} → out_valid 2 cycles after 4th accept; out_min=-1.0, out_max=3.0, out_qscale=0x3C808081 (4/255), out_qzero=-64, out_count=4.
- Samples {1.0, 2.0, 3.0, 4.0} → out_min=0.0, out_max=4.0, out_qscale=0x3C808081, out_qzero=-128.
- Four samples of 0.0 → out_qscale=0x3F800000, out_qzero=0. Separately, flush after 2 samples {-2.0, NaN} → out_count=2, out_min=-2.0, out_max=0.0, out_qzero=127 (clamped).
- Hold out_ready=0 for 5 cycles in HOLD → out_valid stays 1, outputs stable, in_ready=0, samples presented are not accepted. Assert out_ready → in_ready=1 next cycle and the new window starts with count=0.
- Assert rst after 2 of 4 samples, then send 4 new samples {-1, 0.5, 2, 3} → results match the first test, with no contribution from pre-reset samples. flush with empty window produces no out_valid.
- With QUANT_CALIB_SYMMETRIC_EN, samples {-1.0, 0.5, 2.0, 3.0} → out_qscale=real_to_fp32(3/127)≈0.0236220, out_qzero=0, out_min=-3.0, out_max=3.0.
